// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory (registered read)
// between an instruction-fetch port (read-only) and a data load/store port.
// Each access runs IDLE -> CMD -> WAIT -> DONE, so the winner sees its ack
// three cycles after its request is sampled in IDLE. Ties are broken
// round-robin against the last granted port. All outputs are registered.
//
// Ports:
//   CLK, reset         clock and synchronous active-high reset
//   if_req/if_addr     fetch request and word address
//   if_ack/if_rdata/if_err   fetch completion pulse, data, out-of-range flag
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, data
//   d_ack/d_rdata/d_err      data completion pulse, load data, range flag
//   mem_read/mem_write/mem_addr/mem_wdata  memory command side
//   mem_rdata          memory read data (valid the cycle after mem_read)
//   busy               high whenever the sequencer is not idle
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 1024
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_DONE} state_t;

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_WORDS);

    // Unsigned compare over the full address width.
    function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
        return 64'(a) >= MEM_LIMIT;
    endfunction

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1: data port had the last grant
    logic              gnt_d_q, gnt_d_d;     // 1: current access belongs to data port
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;

    // Arbitration: a lone requester wins; on a tie the port that did not
    // win last time gets the grant.
    logic              pick_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_oob;
    logic [DATA_W-1:0] wait_rdata;

    assign pick_d     = d_req & (~if_req | ~last_d_q);
    assign sel_addr   = pick_d ? d_addr : if_addr;
    assign sel_we     = pick_d & d_we;
    assign sel_oob    = addr_oob(sel_addr);
    // Writes and rejected addresses return zero instead of stale memory data.
    assign wait_rdata = (err_q | we_q) ? '0 : mem_rdata;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        gnt_d_d     = gnt_d_q;
        we_d        = we_q;
        err_d       = err_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (if_req | d_req) begin
                    gnt_d_d     = pick_d;
                    last_d_d    = pick_d;
                    we_d        = sel_we;
                    err_d       = sel_oob;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = pick_d ? d_wdata : '0;
                    // Out-of-range addresses are still presented but never strobed.
                    mem_read_d  = ~sel_oob & ~sel_we;
                    mem_write_d = ~sel_oob & sel_we;
                    state_d     = S_CMD;
                end
            end
            S_CMD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (gnt_d_q) begin
                    d_ack_d   = 1'b1;
                    d_rdata_d = wait_rdata;
                    d_err_d   = err_q;
                end else begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = wait_rdata;
                    if_err_d   = err_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_d_q    <= 1'b0;
            gnt_d_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            gnt_d_q     <= gnt_d_d;
            we_q        <= we_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a table of single transactions with full
// cycle-by-cycle timing checks, hand-written tie/reset sequences, and a
// randomized run scored against a transaction-level reference model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        d_err;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(1024)) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Reset-time preload pattern of the memory.
    function automatic logic [15:0] pre_val(input int i);
        if (i == 2) return 16'h2468;
        return 16'(32'h5A00 + i);
    endfunction

    // 1024x16 synchronous memory with registered read; preloads during reset.
    logic [15:0] mem [1024];
    always @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pre_val(i);
            mem_rdata <= 16'h0000;
        end else begin
            if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
            if (mem_read) mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ack"}, if_ack, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_if_err"}, if_err, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_d_err"}, d_err, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        bit          exp_err;
    } txn_t;

    // One isolated transaction: request raised in an IDLE cycle (cycle 0),
    // strobe in cycle 1, quiet cycle 2, ack in cycle 3, request dropped then.
    task automatic run_txn(input txn_t t, input int idx);
        string tag;
        bit    exp_rd, exp_wr;
        tag    = $sformatf("txn%0d", idx);
        exp_rd = !t.exp_err && !t.we;
        exp_wr = !t.exp_err && t.we;
        @(negedge CLK);
        if (t.is_d) begin
            d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end
        chk({tag, "_c0_busy"}, busy, 0);
        @(negedge CLK);
        chk({tag, "_c1_mem_read"}, mem_read, exp_rd);
        chk({tag, "_c1_mem_write"}, mem_write, exp_wr);
        chk({tag, "_c1_mem_addr"}, mem_addr, t.addr);
        if (exp_wr) chk({tag, "_c1_mem_wdata"}, mem_wdata, t.wdata);
        chk({tag, "_c1_busy"}, busy, 1);
        @(negedge CLK);
        chk({tag, "_c2_strobes"}, {mem_read, mem_write}, 0);
        chk({tag, "_c2_acks"}, {if_ack, d_ack}, 0);
        @(negedge CLK);
        if (t.is_d) begin
            chk({tag, "_c3_d_ack"}, d_ack, 1);
            chk({tag, "_c3_if_ack"}, if_ack, 0);
            chk({tag, "_c3_d_rdata"}, d_rdata, t.exp_rdata);
            chk({tag, "_c3_d_err"}, d_err, t.exp_err);
            d_req = 1'b0;
        end else begin
            chk({tag, "_c3_if_ack"}, if_ack, 1);
            chk({tag, "_c3_d_ack"}, d_ack, 0);
            chk({tag, "_c3_if_rdata"}, if_rdata, t.exp_rdata);
            chk({tag, "_c3_if_err"}, if_err, t.exp_err);
            if_req = 1'b0;
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = int'($urandom % 16);
        if (r == 0) return 16'($urandom_range(1024, 65535));
        if (r == 1) return 16'h03FF;
        if (r == 2) return 16'h0400;
        return 16'($urandom % 16);
    endfunction

    // Reference model state for the randomized run.
    logic [15:0] ref_mem [1024];
    int          free_at, stb_cyc, ack_cyc;
    bit          last_d, stb_rd, stb_wr, ack_is_d, ack_err;
    logic [15:0] stb_addr, stb_wdata, ack_rd;
    logic [15:0] exp_if_rdata, exp_d_rdata;
    bit          exp_if_err, exp_d_err;

    txn_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h2468, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h5A11, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h5DFF, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'h0400, 16'h1111, 16'h0000, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A00, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 16'h03FF, 16'h0F0F, 16'h0000, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h0F0F, 1'b0};

        // Reset for three cycles with both ports trying to get in.
        reset = 1'b1;
        if_req = 1'b1; if_addr = 16'h0005;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0006; d_wdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_all_zero($sformatf("rst%0d", i));
        end
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

        for (int i = 0; i < 12; i++) run_txn(tbl[i], i);

        // Both ports requesting continuously: d, if, d.
        @(negedge CLK); reset = 1'b1;
        @(negedge CLK); reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                if_req = 1'b1; if_addr = 16'h0003;
                d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0004;
            end
            chk($sformatf("tie_c%0d_d_ack", c), d_ack, (c == 3 || c == 11));
            chk($sformatf("tie_c%0d_if_ack", c), if_ack, (c == 7));
            if (c == 3 || c == 11) chk($sformatf("tie_c%0d_d_rdata", c), d_rdata, 16'h5A04);
            if (c == 7) chk("tie_c7_if_rdata", if_rdata, 16'h5A03);
        end
        if_req = 1'b0; d_req = 1'b0;

        // Reset during WAIT of a fetch abandons it.
        @(negedge CLK); if_req = 1'b1; if_addr = 16'h0005;
        @(negedge CLK); chk("rmid_c1_mem_read", mem_read, 1);
        @(negedge CLK); reset = 1'b1;
        @(negedge CLK);
        chk_all_zero("rmid_c3");
        reset = 1'b0; if_req = 1'b0;
        @(negedge CLK); chk("rmid_c4_if_ack", if_ack, 0);
        begin
            txn_t t;
            t = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h5A05, 1'b0};
            run_txn(t, 100);
        end

        // Randomized run against the transaction-level model.
        @(negedge CLK); reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pre_val(i);
        free_at = 0; stb_cyc = -1; ack_cyc = -1; last_d = 1'b0;
        stb_rd = 1'b0; stb_wr = 1'b0; ack_is_d = 1'b0; ack_err = 1'b0;
        stb_addr = '0; stb_wdata = '0; ack_rd = '0;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_if_err = 1'b0; exp_d_err = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            if (cyc == ack_cyc) begin
                if (ack_is_d) begin exp_d_rdata = ack_rd; exp_d_err = ack_err; end
                else begin exp_if_rdata = ack_rd; exp_if_err = ack_err; end
            end
            chk("rnd_if_ack", if_ack, (cyc == ack_cyc) && !ack_is_d);
            chk("rnd_d_ack", d_ack, (cyc == ack_cyc) && ack_is_d);
            chk("rnd_if_rdata", if_rdata, exp_if_rdata);
            chk("rnd_if_err", if_err, exp_if_err);
            chk("rnd_d_rdata", d_rdata, exp_d_rdata);
            chk("rnd_d_err", d_err, exp_d_err);
            chk("rnd_mem_read", mem_read, (cyc == stb_cyc) && stb_rd);
            chk("rnd_mem_write", mem_write, (cyc == stb_cyc) && stb_wr);
            chk("rnd_busy", busy, cyc < free_at);
            if (cyc == stb_cyc && (stb_rd || stb_wr)) chk("rnd_mem_addr", mem_addr, stb_addr);
            if (cyc == stb_cyc && stb_wr) chk("rnd_mem_wdata", mem_wdata, stb_wdata);

            // Requesters: hold until acked, then maybe issue another.
            if (cyc == ack_cyc) begin
                if (ack_is_d) d_req = 1'b0; else if_req = 1'b0;
            end
            if (!if_req && ($urandom % 3 == 0)) begin
                if_req = 1'b1; if_addr = rand_addr();
            end
            if (!d_req && ($urandom % 3 == 0)) begin
                d_req = 1'b1; d_we = 1'($urandom % 2);
                d_addr = rand_addr(); d_wdata = 16'($urandom);
            end

            // Model: an idle arbiter serves one request, ack three cycles later.
            if (cyc >= free_at && (if_req || d_req)) begin
                bit          g_d, g_we, g_oob;
                logic [15:0] g_addr;
                g_d    = d_req && (!if_req || !last_d);
                g_addr = g_d ? d_addr : if_addr;
                g_we   = g_d && d_we;
                g_oob  = int'(g_addr) >= 1024;
                last_d = g_d;
                if (!g_oob && g_we) ref_mem[g_addr[9:0]] = d_wdata;
                ack_rd    = (g_oob || g_we) ? 16'h0000 : ref_mem[g_addr[9:0]];
                ack_err   = g_oob;
                ack_is_d  = g_d;
                ack_cyc   = cyc + 3;
                stb_cyc   = cyc + 1;
                stb_rd    = !g_oob && !g_we;
                stb_wr    = !g_oob && g_we;
                stb_addr  = g_addr;
                stb_wdata = d_wdata;
                free_at   = cyc + 4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-port 1024x16 synchronous memory block, which has a registered read (data out the cycle after MemRead).
- Shares the memory between the instruction-fetch port (read-only) and the data load/store port (read/write).
- Serialises accesses, generates the memory's MemRead/MemWrite/ADDR/Data_in, captures read data, and returns a one-cycle acknowledge to the winning requester.
- Round-robin tie-break so neither port starves.

Parameters:
- ADDR_W, 16, width of requester and memory address buses
- DATA_W, 16, data width
- MEM_WORDS, 1024, number of implemented memory words; addresses >= MEM_WORDS are out of range

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata/if_err valid
- if_rdata  out  DATA_W  fetched word
- if_err  out  1  fetch address out of range (valid with if_ack)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load result; 0 for writes and errors
- d_err  out  1  data address out of range (valid with d_ack)
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  ADDR_W  to memory ADDR
- mem_wdata  out  DATA_W  to memory Data_in
- mem_rdata  in  DATA_W  from memory Data_out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: clock CLK; reset is synchronous, active-high.
- Reset values: all outputs 0, FSM = IDLE, last_grant = fetch.
  - mem_read and mem_write are held 0 throughout reset so the memory's reset-time preload is not disturbed.
  - Reset mid-transaction abandons the access: no ack is issued and outputs return to 0 at the next edge.
- FSM: IDLE -> CMD -> WAIT -> DONE -> IDLE. All outputs are registered.
- IDLE, with at least one request pending:
  - Select the winner: a single requester wins; if both request, the port not in last_grant wins.
  - Latch the winner id, address, we and wdata; update last_grant; go to CMD.
  - Range check: in range -> drive mem_addr, and set mem_read = ~we (fetch always reads) and mem_write = we. Out of range -> both strobes 0, error flag latched.
- CMD (strobes high for exactly this one cycle): memory executes at the closing edge; go to WAIT.
- WAIT:
  - Strobes return to 0; mem_rdata is now valid.
  - At the closing edge, capture the winner's rdata: mem_rdata for reads; 0 for writes or errors.
  - Set the winner's ack and err; go to DONE.
- DONE:
  - ack high for exactly this cycle; requests are ignored.
  - rdata and err hold their values until that port's next ack.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle t -> ack high in cycle t+3. Maximum throughput is one access per 4 cycles.
- Back-to-back: a requester may keep req high after ack with new operands, and is re-arbitrated in the next IDLE. With both ports requesting continuously, grants alternate d, if, d, if, ... (data wins the first tie after reset).
- Simultaneous events:
  - A req rising during CMD/WAIT/DONE waits until IDLE.
  - The losing port's req stays pending and is not acknowledged.
- Address check: out of range if addr >= MEM_WORDS (unsigned, full ADDR_W compare). mem_addr is still driven but both strobes stay 0.
- A write followed by a read to the same address returns the new data: the access is serialised, so no hazard exists.

Test Plan:
- Reset with reset=1 for 3 cycles -> all outputs 0, mem_write never 1, busy=0.
- if_req=1, if_addr=2 in cycle 0, memory preloaded with 0x2468 at word 2 -> mem_read=1 only in cycle 1, if_ack=1 in cycle 3, if_rdata=0x2468, if_err=0.
- d_req write addr 0x0010 data 0xBEEF, then read of 0x0010 -> the write ack arrives with d_rdata=0, and the read ack returns 0xBEEF four cycles later.
- Both req held high from cycle 0 -> d_ack at cycle 3, if_ack at 7, d_ack at 11; no port is acknowledged twice in a row.
- d_req read at addr 0x0400 (1024) -> mem_read and mem_write stay 0, d_ack with d_err=1 and d_rdata=0; a following in-range access has err=0.
- reset asserted in WAIT of a fetch -> no if_ack, outputs 0 next cycle; a req after reset is served normally with 3-cycle latency.
